// File: rtl/pc_gen_if.sv
// Instruction-side fetch interface: the PC generator issues a request at an
// address, and memory signals acceptance in the same cycle.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             inst_req;
    logic             inst_addr_ok;
    logic [WIDTH-1:0] pc;

    modport master (
        output inst_req,
        output pc,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req,
        input  pc,
        output inst_addr_ok
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, handshakes with instruction memory,
// applies prioritised redirects and buffers a branch that arrives while fetch is blocked.
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'hbfc00000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'hbfc00380),
    parameter int               INC       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pend_valid,
    output logic             fetch_adel,
    pc_gen_if.master         mem
);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_req_en;

    logic             w_adel;
    logic             w_req;
    logic             w_adv;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pend_valid_next;
    logic [WIDTH-1:0] w_pend_target_next;

    // req_en keeps the very first request one cycle behind reset release.
    assign w_adel = (r_pc[1:0] != 2'b00);
    assign w_req  = r_req_en & ~stall & ~w_adel;
    assign w_adv  = w_req & mem.inst_addr_ok;

    always_comb begin
        w_pc_next          = r_pc;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        if (exc) begin
            w_pc_next         = EXC_VEC;
            w_pend_valid_next = 1'b0;
        end else if (eret) begin
            w_pc_next         = epc;
            w_pend_valid_next = 1'b0;
        end else if (br_take && w_adv) begin
            w_pc_next         = br_target;
            w_pend_valid_next = 1'b0;
        end else if (br_take) begin
            // Latest branch wins over any target already buffered.
            w_pend_valid_next  = 1'b1;
            w_pend_target_next = br_target;
        end else if (r_pend_valid && w_adv) begin
            w_pc_next         = r_pend_target;
            w_pend_valid_next = 1'b0;
        end else if (w_adv) begin
            w_pc_next = r_pc + INC_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_VEC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_req_en      <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
            r_req_en      <= 1'b1;
        end
    end

    assign mem.pc       = r_pc;
    assign mem.inst_req = w_req;
    assign pc_plus      = r_pc + INC_W;
    assign pend_valid   = r_pend_valid;
    assign fetch_adel   = w_adel;
endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: a 32-bit default instance plus a
// 16-bit instance with a different reset vector.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, exc, eret, br_take;
    logic [31:0] epc, br_target;
    logic [31:0] pc_plus;
    logic        pend_valid, fetch_adel;
    logic [15:0] pc_plus16;
    logic        pend_valid16, fetch_adel16;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_gen_if #(.WIDTH(32)) bus32 ();
    pc_gen_if #(.WIDTH(16)) bus16 ();

    pc_gen u_dut (
        .clk(clk), .rst(rst), .stall(stall), .exc(exc), .eret(eret), .epc(epc),
        .br_take(br_take), .br_target(br_target), .pc_plus(pc_plus),
        .pend_valid(pend_valid), .fetch_adel(fetch_adel), .mem(bus32)
    );

    pc_gen #(
        .WIDTH(16), .RESET_VEC(16'h0100), .EXC_VEC(16'h0380), .INC(4)
    ) u_dut16 (
        .clk(clk), .rst(rst), .stall(stall), .exc(1'b0), .eret(1'b0), .epc(16'h0000),
        .br_take(1'b0), .br_target(16'h0000), .pc_plus(pc_plus16),
        .pend_valid(pend_valid16), .fetch_adel(fetch_adel16), .mem(bus16)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; exc = 0; eret = 0; br_take = 0;
        epc = 32'h0; br_target = 32'h0;
        bus32.inst_addr_ok = 1'b1;
        bus16.inst_addr_ok = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00000) begin
            tests_failed++; $display("[TB] FAIL reset_pc: got %h expected bfc00000", bus32.pc);
        end
        tests_run++;
        if (pend_valid !== 1'b0 || bus32.inst_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_flags: pend=%b req=%b expected 0 0", pend_valid, bus32.inst_req);
        end
        rst = 0;
        #1;
        tests_run++;
        if (bus32.inst_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL first_cycle_req: got %b expected 0", bus32.inst_req);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00000 || bus32.inst_req !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL first_req: pc=%h req=%b expected bfc00000 1", bus32.pc, bus32.inst_req);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00004) begin
            tests_failed++; $display("[TB] FAIL seq_pc1: got %h expected bfc00004", bus32.pc);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00008 || pc_plus !== 32'hbfc0000c) begin
            tests_failed++; $display("[TB] FAIL seq_pc2: pc=%h plus=%h expected bfc00008 bfc0000c", bus32.pc, pc_plus);
        end
    endtask

    task automatic test_branch_pending();
        step();
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00010) begin
            tests_failed++; $display("[TB] FAIL reach_10: got %h expected bfc00010", bus32.pc);
        end
        br_take = 1; br_target = 32'hbfc00100; bus32.inst_addr_ok = 0;
        step();
        tests_run++;
        if (pend_valid !== 1'b1 || bus32.pc !== 32'hbfc00010) begin
            tests_failed++; $display("[TB] FAIL br_buffer: pend=%b pc=%h expected 1 bfc00010", pend_valid, bus32.pc);
        end
        br_take = 0; bus32.inst_addr_ok = 1;
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00100 || pend_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL br_release: pc=%h pend=%b expected bfc00100 0", bus32.pc, pend_valid);
        end
        br_take = 1; br_target = 32'hbfc00150; bus32.inst_addr_ok = 0;
        step();
        br_target = 32'hbfc00200;
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00100 || pend_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL br_hold2: pc=%h pend=%b expected bfc00100 1", bus32.pc, pend_valid);
        end
        br_take = 0; bus32.inst_addr_ok = 1;
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00200 || pend_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL br_latest: pc=%h pend=%b expected bfc00200 0", bus32.pc, pend_valid);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00204) begin
            tests_failed++; $display("[TB] FAIL after_br_seq: got %h expected bfc00204", bus32.pc);
        end
    endtask

    task automatic test_exception();
        br_take = 1; br_target = 32'hbfc00300; bus32.inst_addr_ok = 0;
        step();
        tests_run++;
        if (pend_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL exc_setup_pend: got %b expected 1", pend_valid);
        end
        stall = 1; exc = 1; br_target = 32'hbfc00400; bus32.inst_addr_ok = 1;
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00380 || pend_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL exc_wins: pc=%h pend=%b expected bfc00380 0", bus32.pc, pend_valid);
        end
        idle_inputs();
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00384 || pend_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL exc_no_buffer: pc=%h pend=%b expected bfc00384 0", bus32.pc, pend_valid);
        end
        exc = 1; eret = 1; epc = 32'h80000000;
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00380) begin
            tests_failed++; $display("[TB] FAIL exc_over_eret: got %h expected bfc00380", bus32.pc);
        end
        idle_inputs();
    endtask

    task automatic test_eret_misalign();
        eret = 1; epc = 32'h80000002;
        step();
        eret = 0;
        tests_run++;
        if (bus32.pc !== 32'h80000002 || fetch_adel !== 1'b1 || bus32.inst_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL eret_adel: pc=%h adel=%b req=%b expected 80000002 1 0", bus32.pc, fetch_adel, bus32.inst_req);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (bus32.pc !== 32'h80000002) begin
                tests_failed++; $display("[TB] FAIL adel_hold%0d: got %h expected 80000002", i, bus32.pc);
            end
        end
        exc = 1;
        step();
        exc = 0;
        tests_run++;
        if (bus32.pc !== 32'hbfc00380 || fetch_adel !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL adel_recover: pc=%h adel=%b expected bfc00380 0", bus32.pc, fetch_adel);
        end
    endtask

    task automatic test_stall_hold();
        stall = 1;
        step();
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00380 || bus32.inst_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL stall_hold: pc=%h req=%b expected bfc00380 0", bus32.pc, bus32.inst_req);
        end
        stall = 0;
    endtask

    task automatic test_wrap();
        eret = 1; epc = 32'hfffffffc;
        step();
        eret = 0;
        tests_run++;
        if (bus32.pc !== 32'hfffffffc || pc_plus !== 32'h00000000) begin
            tests_failed++; $display("[TB] FAIL wrap_setup: pc=%h plus=%h expected fffffffc 00000000", bus32.pc, pc_plus);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'h00000000 || pc_plus !== 32'h00000004) begin
            tests_failed++; $display("[TB] FAIL wrap: pc=%h plus=%h expected 00000000 00000004", bus32.pc, pc_plus);
        end
    endtask

    task automatic test_reset_mid();
        br_take = 1; br_target = 32'h00000040; bus32.inst_addr_ok = 0;
        step();
        br_take = 0;
        tests_run++;
        if (pend_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL mid_setup_pend: got %b expected 1", pend_valid);
        end
        rst = 1; bus32.inst_addr_ok = 1;
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00000 || pend_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL mid_reset: pc=%h pend=%b expected bfc00000 0", bus32.pc, pend_valid);
        end
        rst = 0;
        #1;
        tests_run++;
        if (bus32.inst_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL mid_req_gap: got %b expected 0", bus32.inst_req);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00000 || bus32.inst_req !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL mid_resume: pc=%h req=%b expected bfc00000 1", bus32.pc, bus32.inst_req);
        end
        step();
        tests_run++;
        if (bus32.pc !== 32'hbfc00004) begin
            tests_failed++; $display("[TB] FAIL mid_seq: got %h expected bfc00004", bus32.pc);
        end
    endtask

    task automatic test_width16();
        idle_inputs();
        rst = 1;
        step();
        tests_run++;
        if (bus16.pc !== 16'h0100 || bus16.inst_req !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL w16_reset: pc=%h req=%b expected 0100 0", bus16.pc, bus16.inst_req);
        end
        rst = 0;
        step();
        tests_run++;
        if (bus16.pc !== 16'h0100 || bus16.inst_req !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL w16_first: pc=%h req=%b expected 0100 1", bus16.pc, bus16.inst_req);
        end
        step();
        tests_run++;
        if (bus16.pc !== 16'h0104) begin
            tests_failed++; $display("[TB] FAIL w16_seq1: got %h expected 0104", bus16.pc);
        end
        step();
        tests_run++;
        if (bus16.pc !== 16'h0108 || pc_plus16 !== 16'h010c) begin
            tests_failed++; $display("[TB] FAIL w16_seq2: pc=%h plus=%h expected 0108 010c", bus16.pc, pc_plus16);
        end
    endtask

    initial begin
        test_reset();
        test_branch_pending();
        test_exception();
        test_eret_misalign();
        test_stall_hold();
        test_wrap();
        test_reset_mid();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-address generator for the MIPS core. It is the next generation of the basic PC register.
- Holds the fetch PC and drives a request/accept handshake to instruction memory.
- Applies prioritised redirects: exception, ERET, branch/jump.
- Buffers a branch redirect that arrives while fetch is blocked.
- Flags misaligned fetch addresses for the exception unit.
Sits between the IF stage and the instruction-side memory interface.

Parameters:
WIDTH, 32, address width in bits (>= 3).
RESET_VEC, 32'hbfc00000, PC value loaded on reset.
EXC_VEC, 32'hbfc00380, PC loaded on exception flush.
INC, 4, sequential increment in bytes.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
stall  in  1  pipeline stall; blocks sequential/branch advance.
exc  in  1  exception flush; redirect to EXC_VEC.
eret  in  1  return from exception; redirect to epc.
epc  in  WIDTH  ERET target.
br_take  in  1  resolved taken branch/jump this cycle.
br_target  in  WIDTH  branch/jump target.
inst_addr_ok  in  1  memory accepts the current request this cycle.
inst_req  out  1  fetch request valid.
pc  out  WIDTH  current fetch address (registered).
pc_plus  out  WIDTH  pc + INC, combinational.
pend_valid  out  1  a buffered branch redirect is waiting.
fetch_adel  out  1  pc misaligned (pc[1:0] != 0), combinational.

Behaviour:
- Reset (rst=1 at edge) sets:
  - pc = RESET_VEC
  - pend_valid = 0, pend_target = 0
  - req_en = 0
  - Reset has priority over every other input.
- inst_req = req_en & ~stall & ~fetch_adel.
  - req_en is a register: 0 in reset, set to 1 on the first edge with rst=0, then stays 1.
  - First request is therefore issued one cycle after reset deasserts, at RESET_VEC.
- advance = inst_req & inst_addr_ok.
- Next-state priority per edge, highest first (rst=0):
  1. exc: pc <= EXC_VEC; pend_valid <= 0. Applies regardless of stall, advance or misalignment.
  2. eret: pc <= epc; pend_valid <= 0. Same override rules as exc.
  3. br_take & advance: pc <= br_target; pend_valid <= 0.
  4. br_take & ~advance: pc holds; pend_valid <= 1; pend_target <= br_target. A new br_take overwrites an existing pending target (latest wins).
  5. pend_valid & advance: pc <= pend_target; pend_valid <= 0.
  6. advance: pc <= pc + INC, modulo 2^WIDTH (wraps to 0, no flag).
  7. Otherwise: pc, pend_valid and pend_target all hold.
- Misaligned fetch:
  - fetch_adel = 1 forces inst_req = 0, so no advance occurs.
  - pc, and any pending target, hold until exc or eret.
- Holding under stall: stall=1 with inst_addr_ok=1 still holds pc, since inst_req=0.
- Simultaneous events:
  - exc with eret: exc wins.
  - exc or eret with br_take: the branch is dropped and not buffered.
- Reset mid-operation: pending redirect discarded; inst_req drops for exactly one cycle after rst falls.
- No combinational path from inputs to pc. Combinational paths exist only to inst_req, pc_plus and fetch_adel.

Test Plan:
1. Reset then free-run. rst 1 for 2 cycles, then 0, stall=0, inst_addr_ok=1.
   - inst_req=0 on the first cycle after reset, then 1.
   - pc sequence bfc00000, bfc00004, bfc00008.
2. Branch under backpressure. At pc=bfc00010, br_take with br_target=bfc00100 while inst_addr_ok=0.
   - pend_valid=1 and pc holds bfc00010.
   - When inst_addr_ok=1: pc=bfc00100 next edge, pend_valid=0.
   - Repeat with a second br_take (target bfc00200) during the hold: pc=bfc00200.
3. Exception beats everything. stall=1 with exc=1, br_take=1 and pend_valid=1 in the same cycle.
   - pc=bfc00380, pend_valid=0, next edge.
   - exc+eret together also gives bfc00380.
4. ERET and misalignment. eret with epc=80000002.
   - pc=80000002, fetch_adel=1, inst_req=0.
   - pc stays 80000002 for 5 cycles with inst_addr_ok=1.
   - exc then restores pc=bfc00380, fetch_adel=0.
5. Wrap-around. Force pc=fffffffc via eret with epc=fffffffc, then advance.
   - pc=00000000 next edge; pc_plus=00000004.
6. Reset mid-operation. Assert rst while pend_valid=1.
   - pc=bfc00000, pend_valid=0.
   - inst_req=0 for one cycle after rst falls.
   - Rerun with WIDTH=16, RESET_VEC=16'h0100: pc=0100, 0104, ...
